// File: rtl/lenet_c3_weight_loader_if.sv
// Byte-stream, write-strobe and status bundle between the C3 weight loader and its neighbours.
// The slave modport is the loader's view; the master modport is the stream source and C3 side.
interface lenet_c3_weight_loader_if #(
   parameter int WW = 8,
   parameter int GP = 6
);
   logic                 i_start;
   logic                 i_hold;
   logic                 i_valid;
   logic [WW-1:0]        i_tdata;
   logic                 o_ready;
   logic [GP-1:0]        o_W_en;
   logic signed [WW-1:0] o_Weight_1;
   logic signed [WW-1:0] o_Weight_2;
   logic signed [WW-1:0] o_Weight_3;
   logic signed [WW-1:0] o_Weight_4;
   logic signed [WW-1:0] o_Weight_5;
   logic signed [WW-1:0] o_Weight_6;
   logic [4:0]           o_W_addr;
   logic signed [WW-1:0] o_Bias;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_err;

   modport slave (
      input  i_start, i_hold, i_valid, i_tdata,
      output o_ready, o_W_en, o_Weight_1, o_Weight_2, o_Weight_3, o_Weight_4, o_Weight_5,
             o_Weight_6, o_W_addr, o_Bias, o_busy, o_done, o_err
   );

   modport master (
      output i_start, i_hold, i_valid, i_tdata,
      input  o_ready, o_W_en, o_Weight_1, o_Weight_2, o_Weight_3, o_Weight_4, o_Weight_5,
             o_Weight_6, o_W_addr, o_Bias, o_busy, o_done, o_err
   );
endinterface

// File: rtl/lenet_c3_weight_loader.sv
// C3 weight/bias loader: gathers one byte per lane, strobes all GP lanes at once per tap, then latches
// the bias. Define C3_WLOAD_CHECKSUM_EN to accept and verify a trailing 8-bit checksum byte.
module lenet_c3_weight_loader #(
   parameter int WW   = 8,
   parameter int GP   = 6,
   parameter int NTAP = 25
) (
   input  logic                      i_sclk,
   input  logic                      i_rst,
   lenet_c3_weight_loader_if.slave   bus
);

`ifdef C3_WLOAD_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_GATHER, S_WRITE, S_BIAS, S_CHECK, S_DONE} state_t;
   localparam state_t S_AFTER_BIAS = S_CHECK;
`else
   typedef enum logic [2:0] {S_IDLE, S_GATHER, S_WRITE, S_BIAS, S_DONE} state_t;
   localparam state_t S_AFTER_BIAS = S_DONE;
`endif

   localparam int            CW     = (GP > 1) ? $clog2(GP) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(GP - 1);
   localparam logic [4:0]    A_LAST = 5'(NTAP - 1);

   state_t               r_state;
   state_t               w_next;
   logic                 w_accept;
   logic                 w_last_lane;
   logic                 w_strobe;
   logic                 w_ready_next;
   logic [WW-1:0]        w_lane [GP];
   logic [WW-1:0]        r_lane [GP];
   logic signed [WW-1:0] r_weight [GP];
   logic [CW-1:0]        r_c;
   logic [4:0]           r_a;
   logic [4:0]           r_addr;
   logic                 r_ready;
   logic                 r_strobe;
   logic                 r_busy;
   logic                 r_done;
   logic signed [WW-1:0] r_bias;
`ifdef C3_WLOAD_CHECKSUM_EN
   logic [WW-1:0]        r_sum;
   logic [WW-1:0]        r_bias_stage;
   logic                 r_err;
   logic                 w_chk_ok;

   assign w_chk_ok = (bus.i_tdata == r_sum);
`endif

   // Lane image including the byte being accepted this cycle, so the strobe can carry the full group.
   always_comb begin
      w_accept    = bus.i_valid & r_ready;
      w_last_lane = (r_c == C_LAST);
      for (int k = 0; k < GP; k++) begin
         w_lane[k] = (r_state == S_GATHER && w_accept && r_c == CW'(k)) ? bus.i_tdata : r_lane[k];
      end
   end

   always_comb begin
      w_next   = r_state;
      w_strobe = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.i_start) w_next = S_GATHER;
         end
         S_GATHER: begin
            if (w_accept && w_last_lane) begin
               w_next   = S_WRITE;
               w_strobe = ~bus.i_hold;
            end
         end
         S_WRITE: begin
            // r_strobe high means the strobe is on the wires this cycle; otherwise still held off.
            if (r_strobe) w_next = (r_a == A_LAST) ? S_BIAS : S_GATHER;
            else          w_strobe = ~bus.i_hold;
         end
         S_BIAS: begin
            if (w_accept) w_next = S_AFTER_BIAS;
         end
`ifdef C3_WLOAD_CHECKSUM_EN
         S_CHECK: begin
            if (w_accept) w_next = S_DONE;
         end
`endif
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_ready_next = (w_next == S_GATHER) || (w_next == S_BIAS);
`ifdef C3_WLOAD_CHECKSUM_EN
      if (w_next == S_CHECK) w_ready_next = 1'b1;
`endif
   end

   always_ff @(posedge i_sclk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_ready  <= 1'b0;
         r_strobe <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_a      <= '0;
         r_c      <= '0;
         r_addr   <= '0;
         r_bias   <= '0;
         for (int k = 0; k < GP; k++) r_weight[k] <= '0;
`ifdef C3_WLOAD_CHECKSUM_EN
         r_sum    <= '0;
         r_err    <= 1'b0;
`endif
      end else begin
         r_state  <= w_next;
         r_ready  <= w_ready_next;
         r_strobe <= w_strobe;
         r_busy   <= (w_next != S_IDLE);
         r_done   <= (w_next == S_DONE);

         if (r_state == S_IDLE && bus.i_start) begin
            r_a <= '0;
            r_c <= '0;
         end
         if (r_state == S_GATHER && w_accept) r_c <= w_last_lane ? '0 : r_c + 1'b1;
         if (r_state == S_WRITE && r_strobe)  r_a <= r_a + 1'b1;

         if (w_strobe) begin
            r_addr <= r_a;
            for (int k = 0; k < GP; k++) r_weight[k] <= $signed(w_lane[k]);
         end

`ifdef C3_WLOAD_CHECKSUM_EN
         if (r_state == S_IDLE && bus.i_start) begin
            r_sum <= '0;
            r_err <= 1'b0;
         end
         if (w_accept && (r_state == S_GATHER || r_state == S_BIAS)) r_sum <= r_sum + bus.i_tdata;
         // A bad checksum still finishes the load but leaves the previous bias in service.
         if (r_state == S_CHECK && w_accept) begin
            if (w_chk_ok) r_bias <= $signed(r_bias_stage);
            else          r_err  <= 1'b1;
         end
`else
         if (r_state == S_BIAS && w_accept) r_bias <= $signed(bus.i_tdata);
`endif
      end
   end

   always_ff @(posedge i_sclk) begin
      for (int k = 0; k < GP; k++) r_lane[k] <= w_lane[k];
`ifdef C3_WLOAD_CHECKSUM_EN
      if (r_state == S_BIAS && w_accept) r_bias_stage <= bus.i_tdata;
`endif
   end

   assign bus.o_ready    = r_ready;
   assign bus.o_W_en     = {GP{r_strobe}};
   assign bus.o_Weight_1 = r_weight[0];
   assign bus.o_Weight_2 = r_weight[1];
   assign bus.o_Weight_3 = r_weight[2];
   assign bus.o_Weight_4 = r_weight[3];
   assign bus.o_Weight_5 = r_weight[4];
   assign bus.o_Weight_6 = r_weight[5];
   assign bus.o_W_addr   = r_addr;
   assign bus.o_Bias     = r_bias;
   assign bus.o_busy     = r_busy;
   assign bus.o_done     = r_done;
`ifdef C3_WLOAD_CHECKSUM_EN
   assign bus.o_err      = r_err;
`else
   assign bus.o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_lenet_c3_weight_loader.sv
// Scoreboard bench for lenet_c3_weight_loader: the driver pushes expected strobes and load completions,
// a negedge monitor pops and compares them. Honours C3_WLOAD_CHECKSUM_EN for the trailing checksum byte.
module tb_lenet_c3_weight_loader;
   localparam int WW   = 8;
   localparam int GP   = 6;
   localparam int NTAP = 25;
`ifdef C3_WLOAD_CHECKSUM_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   typedef struct packed {
      logic [4:0]             addr;
      logic [GP-1:0][WW-1:0]  w;
   } wr_t;
   typedef struct packed {
      logic [WW-1:0] bias;
      logic          err;
   } dn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lenet_c3_weight_loader_if #(.WW(WW), .GP(GP)) bus ();

   lenet_c3_weight_loader #(.WW(WW), .GP(GP), .NTAP(NTAP)) dut (
      .i_sclk (clk),
      .i_rst  (rst),
      .bus    (bus.slave)
   );

   wr_t           wr_q[$];
   dn_t           dn_q[$];
   int            tests      = 0;
   int            fails      = 0;
   int            cyc        = 0;
   int            done_cyc   = 0;
   int            done_cnt   = 0;
   logic [WW-1:0] model_bias = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe and every completion must match the next queued expectation.
   always @(negedge clk) begin
      if (bus.o_W_en != '0) begin
         check("wen_all_lanes", bus.o_W_en, {GP{1'b1}});
         if (wr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got addr %0d, expected no strobe", bus.o_W_addr);
         end else begin
            wr_t e;
            e = wr_q.pop_front();
            check("strobe_addr", bus.o_W_addr, e.addr);
            check("strobe_weights", {bus.o_Weight_6, bus.o_Weight_5, bus.o_Weight_4,
                                     bus.o_Weight_3, bus.o_Weight_2, bus.o_Weight_1}, e.w);
         end
      end
      if (bus.o_done) begin
         done_cyc = cyc;
         done_cnt++;
         if (dn_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got o_done, expected none");
         end else begin
            dn_t d;
            d = dn_q.pop_front();
            check("done_bias", $unsigned(bus.o_Bias), d.bias);
            check("done_err", bus.o_err, d.err);
         end
      end
   end

   task automatic send(input logic [7:0] b, input bit gaps, input bit pulse);
      int n;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            bus.i_valid = 1'b0;
            @(negedge clk);
         end
      end
      bus.i_valid = 1'b1;
      bus.i_tdata = b;
      if (pulse) bus.i_start = 1'b1;
      n = 0;
      while (!bus.o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got o_ready=0 for 100 cycles, expected byte %0h taken", b);
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_start = 1'b0;
   endtask

   // One kernel set: start, GP*NTAP weights, bias, optional checksum. abort_at>=0 stops early.
   task automatic load(input bit gaps, input int pulse_at, input int hold_tap, input int abort_at,
                       input bit corrupt, input logic [7:0] bias, input bit seq);
      logic [7:0] w;
      logic [7:0] sum;
      logic [7:0] pre_bias;
      wr_t        e;
      dn_t        d;
      int         t0;
      int         tgt;
      int         n;
      sum      = '0;
      pre_bias = model_bias;
      e        = '0;
      @(negedge clk);
      check("idle_busy", bus.o_busy, 1'b0);
      check("idle_ready", bus.o_ready, 1'b0);
      bus.i_start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      bus.i_start = 1'b0;
      check("busy_after_start", bus.o_busy, 1'b1);
      for (int i = 0; i < GP * NTAP; i++) begin
         if (i == abort_at) return;
         w = seq ? 8'(i) : 8'($urandom_range(0, 255));
         e.w[i % GP] = w;
         sum = sum + w;
         if (i % GP == GP - 1) begin
            e.addr = 5'(i / GP);
            wr_q.push_back(e);
         end
         if (i / GP == hold_tap && i % GP == GP - 1) bus.i_hold = 1'b1;
         if (i == 75) check("bias_held_mid_load", $unsigned(bus.o_Bias), pre_bias);
         send(w, gaps, i == pulse_at);
         if (bus.i_hold) begin
            for (int j = 0; j < 10; j++) begin
               check("hold_no_strobe", bus.o_W_en, '0);
               check("hold_no_ready", bus.o_ready, 1'b0);
               @(negedge clk);
            end
            bus.i_hold = 1'b0;
         end
      end
      if (!(corrupt && CHK == 1)) model_bias = bias;
      d.bias = model_bias;
      d.err  = corrupt && (CHK == 1);
      dn_q.push_back(d);
      sum = sum + bias;
      tgt = done_cnt + 1;
      send(bias, gaps, 1'b0);
      if (CHK == 1) send(corrupt ? sum + 8'd1 : sum, gaps, 1'b0);
      n = 0;
      while (done_cnt < tgt && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (done_cnt < tgt) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got no o_done, expected one within 20 cycles");
      end else if (!gaps && hold_tap < 0) begin
         // Counted inclusively: the i_start cycle is cycle 1, the o_done cycle is the last.
         check("done_latency", 64'(done_cyc - t0 + 1), 64'(178 + CHK));
      end
      check("bias_after_done", $unsigned(bus.o_Bias), model_bias);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.i_start = 1'b0;
      bus.i_hold  = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_tdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", bus.o_ready, 1'b0);
      check("rst_wen", bus.o_W_en, '0);
      check("rst_weights", {bus.o_Weight_6, bus.o_Weight_5, bus.o_Weight_4,
                            bus.o_Weight_3, bus.o_Weight_2, bus.o_Weight_1}, '0);
      check("rst_addr", bus.o_W_addr, '0);
      check("rst_bias", $unsigned(bus.o_Bias), '0);
      check("rst_busy", bus.o_busy, 1'b0);
      check("rst_done", bus.o_done, 1'b0);
      check("rst_err", bus.o_err, 1'b0);
      rst = 1'b0;

      // Sequential weights 0x00..0x95, bias -13, stray i_start mid-load.
      load(1'b0, 60, -1, -1, 1'b0, 8'hF3, 1'b1);
      check("bias_signed", 64'(int'(bus.o_Bias)), 64'(-13));

      // Random weights with random valid gaps.
      load(1'b1, -1, -1, -1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
      load(1'b1, -1, -1, -1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);

      // i_hold across the tap-7 write.
      load(1'b0, -1, 7, -1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);

      // Reset after 40 bytes, then a clean load with bias 5.
      load(1'b0, -1, -1, 40, 1'b0, 8'h11, 1'b0);
      bus.i_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_bias = '0;
      check("bias_after_rst", $unsigned(bus.o_Bias), '0);
      check("busy_after_rst", bus.o_busy, 1'b0);
      check("strobes_before_rst", 64'(wr_q.size()), 64'(0));
      load(1'b0, -1, -1, -1, 1'b0, 8'h05, 1'b0);

`ifdef C3_WLOAD_CHECKSUM_EN
      load(1'b0, -1, -1, -1, 1'b0, 8'h3C, 1'b0);
      check("err_clear_good_sum", bus.o_err, 1'b0);
      load(1'b1, -1, -1, -1, 1'b1, 8'h7E, 1'b0);
      check("err_set_bad_sum", bus.o_err, 1'b1);
      check("bias_kept_bad_sum", $unsigned(bus.o_Bias), 8'h3C);
      load(1'b0, -1, -1, -1, 1'b0, 8'h21, 1'b0);
      check("err_cleared_next_load", bus.o_err, 1'b0);
`endif

      repeat (3) @(negedge clk);
      check("strobe_queue_drained", 64'(wr_q.size()), 64'(0));
      check("done_queue_drained", 64'(dn_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
